operand_entry_ctrl: RTL and testbench

Front-end input controller for the divider datapath. It synchronizes and debounces a raw push-button and captures the board switches as dividend, then divisor. It then issues a one-cycle start pulse to the divider and waits for the divider's completion before accepting a new operand pair. Outputs num_a/num_b feed the divider's A/B inputs; state_leds drive board LEDs.

---
 rtl/operand_entry_ctrl.sv | 151 +++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl.sv
// Operand entry controller for the divider front end.
// A raw push-button is synchronised and debounced. Each accepted press
// captures the slide switches, first as the dividend and then as the divisor.
// The controller then fires a one-cycle start pulse and waits for the divider
// to finish before it accepts a new operand pair.
module operand_entry_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEB_LEN = 50000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             div_done,
    output logic [WIDTH-1:0] num_a,
    output logic [WIDTH-1:0] num_b,
    output logic             start,
    output logic [1:0]       state_leds,
    output logic             div_zero_err
);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        START = 2'b10,
        WAIT  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_LEN - 1);

    logic             sync1;
    logic             btn_s;
    logic [1:0]       sync_valid;
    logic             armed;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;
    logic             enter_pulse;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] num_a_next;
    logic [WIDTH-1:0] num_b_next;
    logic             err_next;
    logic             start_next;

    // Two-flop synchroniser for the raw button. sync_valid marks when both
    // flops hold real post-reset samples; armed is set once the button has
    // been seen released, so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            btn_s      <= 1'b0;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync1      <= btn_enter;
            btn_s      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && !btn_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Debounce: the level only follows btn_s after DEB_LEN consecutive mismatched cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (btn_s == deb) begin
            cnt <= '0;
        end else if (cnt == DEB_LAST) begin
            deb <= btn_s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
        end
    end

    assign enter_pulse = deb & ~deb_d & armed;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= GET_A;
            num_a        <= '0;
            num_b        <= '0;
            div_zero_err <= 1'b0;
            start        <= 1'b0;
        end else begin
            state        <= state_next;
            num_a        <= num_a_next;
            num_b        <= num_b_next;
            div_zero_err <= err_next;
            start        <= start_next;
        end
    end

    // Next-state and capture decisions; start is high exactly while in START.
    always_comb begin
        state_next = state;
        num_a_next = num_a;
        num_b_next = num_b;
        err_next   = div_zero_err;
        case (state)
            GET_A: begin
                if (enter_pulse) begin
                    num_a_next = sw;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (enter_pulse) begin
                    if (sw == '0) begin
                        err_next = 1'b1;
                    end else begin
                        num_b_next = sw;
                        err_next   = 1'b0;
                        state_next = START;
                    end
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase
        start_next = (state_next == START);
    end

    assign state_leds = state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed self-checking bench for operand_entry_ctrl with a short debounce.
module tb_operand_entry_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEB_LEN = 4;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] sw;
    logic             btn_enter;
    logic             div_done;
    logic [WIDTH-1:0] num_a;
    logic [WIDTH-1:0] num_b;
    logic             start;
    logic [1:0]       state_leds;
    logic             div_zero_err;

    int compared   = 0;
    int mismatched = 0;

    int start_cycles = 0;
    int start_run    = 0;
    int start_max    = 0;
    int start_before;

    operand_entry_ctrl #(
        .WIDTH  (WIDTH),
        .DEB_LEN(DEB_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .btn_enter   (btn_enter),
        .div_done    (div_done),
        .num_a       (num_a),
        .num_b       (num_b),
        .start       (start),
        .state_leds  (state_leds),
        .div_zero_err(div_zero_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start-high cycles and the longest run, sampled away from the active edge.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cycles++;
            start_run++;
            if (start_run > start_max) start_max = start_run;
        end else begin
            start_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Set the switches, hold the button high for 'hold' cycles, then release
    // it long enough for the debounced level to settle low again.
    task automatic applyStimulus(input logic [WIDTH-1:0] sw_val, input int hold);
        sw        = sw_val;
        btn_enter = 1'b1;
        cycles(hold);
        btn_enter = 1'b0;
        cycles(12);
    endtask

    task automatic pulseDone();
        div_done = 1'b1;
        cycles(1);
        div_done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        sw        = '0;
        btn_enter = 1'b1;
        div_done  = 1'b0;
        @(negedge clk);

        // Reset held with the button pressed.
        cycles(3);
        checkOutput("rst_num_a", num_a, 0);
        checkOutput("rst_num_b", num_b, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_state", state_leds, 2'b00);
        checkOutput("rst_err", div_zero_err, 0);

        // Button still held after reset release must not count as a press.
        sw    = 8'd99;
        reset = 1'b0;
        cycles(15);
        checkOutput("held_state", state_leds, 2'b00);
        checkOutput("held_num_a", num_a, 0);
        btn_enter = 1'b0;
        cycles(12);

        // Normal entry with latency checks around the capture edge.
        sw        = 8'd100;
        btn_enter = 1'b1;
        cycles(DEB_LEN + 1);
        checkOutput("lat_early_num_a", num_a, 0);
        cycles(3);
        checkOutput("lat_num_a", num_a, 100);
        checkOutput("lat_state", state_leds, 2'b01);
        cycles(2);
        btn_enter = 1'b0;
        cycles(12);

        start_before = start_cycles;
        applyStimulus(8'd7, 10);
        checkOutput("b_num_b", num_b, 7);
        checkOutput("b_state", state_leds, 2'b11);
        checkOutput("b_start_count", start_cycles - start_before, 1);
        checkOutput("b_start_width", start_max, 1);
        checkOutput("b_num_a_held", num_a, 100);

        // Presses in WAIT are ignored.
        start_before = start_cycles;
        applyStimulus(8'd55, 10);
        applyStimulus(8'd56, 10);
        checkOutput("wait_num_a", num_a, 100);
        checkOutput("wait_num_b", num_b, 7);
        checkOutput("wait_state", state_leds, 2'b11);
        checkOutput("wait_no_start", start_cycles - start_before, 0);
        pulseDone();
        checkOutput("done_state", state_leds, 2'b00);
        checkOutput("done_num_b_kept", num_b, 7);

        // Bounce rejection in GET_A.
        sw = 8'd33;
        for (int i = 0; i < 4; i++) begin
            btn_enter = (i % 2 == 0);
            cycles(1);
        end
        btn_enter = 1'b0;
        cycles(12);
        checkOutput("bounce_state", state_leds, 2'b00);
        checkOutput("bounce_num_a", num_a, 100);
        applyStimulus(8'd33, 3);
        checkOutput("short_state", state_leds, 2'b00);
        checkOutput("short_num_a", num_a, 100);
        applyStimulus(8'd33, 4);
        checkOutput("stable_state", state_leds, 2'b01);
        checkOutput("stable_num_a", num_a, 33);

        // div_done outside WAIT does nothing.
        pulseDone();
        checkOutput("stray_done_state", state_leds, 2'b01);

        // Zero divisor is rejected, then a valid one is accepted.
        start_before = start_cycles;
        applyStimulus(8'd0, 10);
        checkOutput("zero_err", div_zero_err, 1);
        checkOutput("zero_num_b", num_b, 7);
        checkOutput("zero_state", state_leds, 2'b01);
        checkOutput("zero_no_start", start_cycles - start_before, 0);
        applyStimulus(8'd5, 10);
        checkOutput("nz_err", div_zero_err, 0);
        checkOutput("nz_num_b", num_b, 5);
        checkOutput("nz_start_count", start_cycles - start_before, 1);
        checkOutput("nz_state", state_leds, 2'b11);

        // New operation after completion captures fresh dividend.
        pulseDone();
        applyStimulus(8'd200, 10);
        checkOutput("new_num_a", num_a, 200);
        checkOutput("new_state", state_leds, 2'b01);
        applyStimulus(8'd9, 10);
        checkOutput("new_wait_state", state_leds, 2'b11);

        // Reset in WAIT together with div_done.
        start_before = start_cycles;
        reset    = 1'b1;
        div_done = 1'b1;
        cycles(1);
        checkOutput("mid_rst_num_a", num_a, 0);
        checkOutput("mid_rst_num_b", num_b, 0);
        checkOutput("mid_rst_state", state_leds, 2'b00);
        checkOutput("mid_rst_err", div_zero_err, 0);
        checkOutput("mid_rst_start", start, 0);
        reset    = 1'b0;
        div_done = 1'b0;
        cycles(3);
        checkOutput("mid_rst_no_start", start_cycles - start_before, 0);
        checkOutput("final_start_width", start_max, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
